// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipeline stage buffer.
//   INST_NOP : bubble instruction shown when the stage holds no entry
//   InstBus  : instruction word width
//   state_e  : occupancy state encoding (EMPTY=0, ONE=1, FULL=2)
package pipe_stage_buf_pkg;

  localparam int unsigned InstBus = 32;

  localparam logic [InstBus-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between two core stages plus the ctrl hold/flush lines.
//   slave  : stage-buffer side (consumes s_*, hold, flush; produces m_*, s_ready, cnt)
//   master : environment side (the mirror image)
interface pipe_stage_buf_if #(
  parameter int unsigned DW = 64
);
  import pipe_stage_buf_pkg::*;

  logic               s_valid_i;
  logic               s_ready_o;
  logic [InstBus-1:0] s_inst_i;
  logic [DW-1:0]      s_data_i;
  logic               m_valid_o;
  logic               m_ready_i;
  logic [InstBus-1:0] m_inst_o;
  logic [DW-1:0]      m_data_o;
  logic               hold_i;
  logic               flush_i;
  logic [1:0]         cnt_o;

  modport slave (
    input  s_valid_i, s_inst_i, s_data_i, m_ready_i, hold_i, flush_i,
    output s_ready_o, m_valid_o, m_inst_o, m_data_o, cnt_o
  );

  modport master (
    output s_valid_i, s_inst_i, s_data_i, m_ready_i, hold_i, flush_i,
    input  s_ready_o, m_valid_o, m_inst_o, m_data_o, cnt_o
  );

endinterface

// File: rtl/gnrl_dfflrd.sv
// Load-enable flip-flop with asynchronous active-low reset to a default value.
//   clk, rstn : clock, async active-low reset
//   lden      : load enable
//   dnxt      : next value
//   qout      : registered value (DEFAULT after reset)
module gnrl_dfflrd #(
  parameter int unsigned     DW      = 32,
  parameter logic [DW-1:0]   DEFAULT = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qout <= DEFAULT;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage register with valid/ready handshake.
//   clk, rstn : clock, async active-low reset
//   bus       : s_* upstream side, m_* downstream side, hold/flush ctrl, cnt occupancy
// SKID=1 gives a 2-entry skid buffer whose s_ready_o depends only on registered
// state; SKID=0 gives a single entry with s_ready_o following m_ready_i.
// An empty main register always carries {INST_NOP, 0} so the next stage sees a bubble.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned        DW       = 64,
  parameter bit                 SKID     = 1'b1,
  parameter logic [InstBus-1:0] INST_NOP = pipe_stage_buf_pkg::INST_NOP
) (
  input  logic                clk,
  input  logic                rstn,
  pipe_stage_buf_if.slave     bus
);

  localparam int unsigned    EW       = InstBus + DW;
  localparam logic [EW-1:0]  EntryNop = {INST_NOP, {DW{1'b0}}};

  state_e          state_q, state_d;
  logic            main_valid, skid_valid;
  logic            s_ready, m_valid;
  logic            push, pop;
  logic [EW-1:0]   in_entry;
  logic [EW-1:0]   main_q, main_d, skid_q, skid_d;
  logic            main_en, skid_en;

  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);
  assign in_entry   = {bus.s_inst_i, bus.s_data_i};

  always_comb begin
    if (SKID) begin
      s_ready = !skid_valid && !bus.hold_i;
    end else begin
      s_ready = (!main_valid || bus.m_ready_i) && !bus.hold_i;
    end
    m_valid = main_valid && !bus.hold_i;
    push    = bus.s_valid_i && s_ready;
    pop     = m_valid && bus.m_ready_i;
  end

  // Next state and register loads; flush wins over everything, hold freezes.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = main_q;
    skid_en = 1'b0;
    skid_d  = skid_q;
    if (bus.flush_i) begin
      state_d = StEmpty;
      main_en = 1'b1;
      main_d  = EntryNop;
      skid_en = 1'b1;
      skid_d  = EntryNop;
    end else if (!bus.hold_i) begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StOne;
            main_en = 1'b1;
            main_d  = in_entry;
          end
        end
        StOne: begin
          if (push && pop) begin
            main_en = 1'b1;
            main_d  = in_entry;
          end else if (push && SKID) begin
            state_d = StFull;
            skid_en = 1'b1;
            skid_d  = in_entry;
          end else if (pop) begin
            state_d = StEmpty;
            main_en = 1'b1;
            main_d  = EntryNop;
          end
        end
        StFull: begin
          // s_ready is low here, so only a pop can happen; skid moves up to keep order.
          if (pop) begin
            state_d = StOne;
            main_en = 1'b1;
            main_d  = skid_q;
            skid_en = 1'b1;
            skid_d  = EntryNop;
          end
        end
        default: begin
          state_d = StEmpty;
          main_en = 1'b1;
          main_d  = EntryNop;
          skid_en = 1'b1;
          skid_d  = EntryNop;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  gnrl_dfflrd #(
    .DW      (EW),
    .DEFAULT (EntryNop)
  ) u_main_reg (
    .clk  (clk),
    .rstn (rstn),
    .lden (main_en),
    .dnxt (main_d),
    .qout (main_q)
  );

  // With SKID=0 the FSM never reaches FULL, so this register never loads.
  gnrl_dfflrd #(
    .DW      (EW),
    .DEFAULT (EntryNop)
  ) u_skid_reg (
    .clk  (clk),
    .rstn (rstn),
    .lden (skid_en),
    .dnxt (skid_d),
    .qout (skid_q)
  );

  always_comb begin
    bus.s_ready_o = s_ready;
    bus.m_valid_o = m_valid;
    bus.m_inst_o  = main_q[EW-1 -: InstBus];
    bus.m_data_o  = main_q[DW-1:0];
    bus.cnt_o     = {1'b0, main_valid} + {1'b0, skid_valid};
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  localparam int unsigned DW1 = 64;
  localparam int unsigned DW0 = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pipe_stage_buf_if #(.DW(DW1)) if1 ();
  pipe_stage_buf_if #(.DW(DW0)) if0 ();

  pipe_stage_buf #(.DW(DW1), .SKID(1'b1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  pipe_stage_buf #(.DW(DW0), .SKID(1'b0)) u_dut0 (.clk(clk), .rstn(rstn), .bus(if0));

  ent_t q1[$];
  ent_t q0[$];
  ent_t e1, e0;
  int   total = 0;
  int   bad   = 0;
  int   pops0 = 0;
  int   p0_start;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: pop/compare on delivery first (main leaves before the new entry lands).
  always @(negedge clk) begin
    if (rstn) begin
      if (if1.flush_i) begin
        q1.delete();
      end else begin
        if (if1.m_valid_o && if1.m_ready_i) begin
          check_val("sb1_has_entry", 64'(q1.size() != 0), 64'd1);
          if (q1.size() != 0) begin
            e1 = q1.pop_front();
            check_val("sb1_inst", 64'(if1.m_inst_o), 64'(e1.inst));
            check_val("sb1_data", if1.m_data_o, e1.data);
          end
        end
        if (if1.s_valid_i && if1.s_ready_o) q1.push_back('{inst: if1.s_inst_i, data: if1.s_data_i});
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (if0.flush_i) begin
        q0.delete();
      end else begin
        if (if0.m_valid_o && if0.m_ready_i) begin
          pops0++;
          check_val("sb0_has_entry", 64'(q0.size() != 0), 64'd1);
          if (q0.size() != 0) begin
            e0 = q0.pop_front();
            check_val("sb0_inst", 64'(if0.m_inst_o), 64'(e0.inst));
            check_val("sb0_data", 64'(if0.m_data_o), e0.data);
          end
        end
        if (if0.s_valid_i && if0.s_ready_o)
          q0.push_back('{inst: if0.s_inst_i, data: 64'(if0.s_data_i)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn          = 1'b0;
    if1.s_valid_i = 1'b0;
    if1.s_inst_i  = '0;
    if1.s_data_i  = '0;
    if1.m_ready_i = 1'b1;
    if1.hold_i    = 1'b0;
    if1.flush_i   = 1'b0;
    if0.s_valid_i = 1'b0;
    if0.s_inst_i  = '0;
    if0.s_data_i  = '0;
    if0.m_ready_i = 1'b1;
    if0.hold_i    = 1'b0;
    if0.flush_i   = 1'b0;

    #12;
    check_val("rst_m_valid", 64'(if1.m_valid_o), 64'd0);
    check_val("rst_m_inst", 64'(if1.m_inst_o), 64'(NOP));
    check_val("rst_m_data", if1.m_data_o, 64'd0);
    check_val("rst_cnt", 64'(if1.cnt_o), 64'd0);
    check_val("rst_s_ready", 64'(if1.s_ready_o), 64'd1);
    check_val("rst0_m_inst", 64'(if0.m_inst_o), 64'(NOP));
    @(negedge clk);
    rstn = 1'b1;

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      step();
      if1.s_valid_i = 1'b1;
      if1.s_inst_i  = 32'h00A0_0093 + 32'(i) * 32'h0010_0000;
      if1.s_data_i  = {$urandom, $urandom};
      #3;
      check_val("stream_s_ready", 64'(if1.s_ready_o), 64'd1);
      if (i == 0) begin
        check_val("stream_cnt0", 64'(if1.cnt_o), 64'd0);
      end else begin
        check_val("stream_cnt", 64'(if1.cnt_o), 64'd1);
        check_val("stream_inst", 64'(if1.m_inst_o),
                  64'(32'h00A0_0093 + 32'(i - 1) * 32'h0010_0000));
      end
    end
    step();
    if1.s_valid_i = 1'b0;
    #3;
    check_val("stream_last_inst", 64'(if1.m_inst_o), 64'h00D0_0093);
    check_val("stream_last_cnt", 64'(if1.cnt_o), 64'd1);
    step();
    #3;
    check_val("stream_drain_cnt", 64'(if1.cnt_o), 64'd0);
    check_val("stream_drain_valid", 64'(if1.m_valid_o), 64'd0);
    check_val("stream_drain_inst", 64'(if1.m_inst_o), 64'(NOP));
    check_val("stream_drain_data", if1.m_data_o, 64'd0);

    // Backpressure fills the skid
    step();
    if1.m_ready_i = 1'b0;
    if1.s_valid_i = 1'b1;
    if1.s_inst_i  = 32'h11;
    if1.s_data_i  = 64'h11;
    step();
    if1.s_inst_i  = 32'h22;
    if1.s_data_i  = 64'h22;
    #3;
    check_val("bp_one_cnt", 64'(if1.cnt_o), 64'd1);
    check_val("bp_one_ready", 64'(if1.s_ready_o), 64'd1);
    check_val("bp_one_inst", 64'(if1.m_inst_o), 64'h11);
    step();
    if1.s_inst_i  = 32'h33;
    if1.s_data_i  = 64'h33;
    #3;
    check_val("bp_full_cnt", 64'(if1.cnt_o), 64'd2);
    check_val("bp_full_ready", 64'(if1.s_ready_o), 64'd0);
    check_val("bp_full_inst", 64'(if1.m_inst_o), 64'h11);
    step();
    if1.s_valid_i = 1'b0;
    if1.m_ready_i = 1'b1;
    #3;
    check_val("bp_release_ready", 64'(if1.s_ready_o), 64'd0);
    step();
    #3;
    check_val("bp_second_inst", 64'(if1.m_inst_o), 64'h22);
    check_val("bp_second_cnt", 64'(if1.cnt_o), 64'd1);
    check_val("bp_second_ready", 64'(if1.s_ready_o), 64'd1);
    step();
    #3;
    check_val("bp_drain_cnt", 64'(if1.cnt_o), 64'd0);

    // Hold in FULL
    step();
    if1.m_ready_i = 1'b0;
    if1.s_valid_i = 1'b1;
    if1.s_inst_i  = 32'h101;
    if1.s_data_i  = 64'hA1;
    step();
    if1.s_inst_i  = 32'h102;
    if1.s_data_i  = 64'hA2;
    step();
    if1.hold_i    = 1'b1;
    if1.m_ready_i = 1'b1;
    if1.s_inst_i  = 32'h103;
    if1.s_data_i  = 64'hA3;
    for (int k = 0; k < 3; k++) begin
      #3;
      check_val("hold_m_valid", 64'(if1.m_valid_o), 64'd0);
      check_val("hold_s_ready", 64'(if1.s_ready_o), 64'd0);
      check_val("hold_cnt", 64'(if1.cnt_o), 64'd2);
      step();
    end
    if1.hold_i    = 1'b0;
    if1.s_valid_i = 1'b0;
    #3;
    check_val("hold_rel_valid", 64'(if1.m_valid_o), 64'd1);
    check_val("hold_rel_inst", 64'(if1.m_inst_o), 64'h101);
    step();
    #3;
    check_val("hold_rel_inst2", 64'(if1.m_inst_o), 64'h102);
    step();
    #3;
    check_val("hold_drain_cnt", 64'(if1.cnt_o), 64'd0);

    // Flush in FULL with push and pop offered
    step();
    if1.m_ready_i = 1'b0;
    if1.s_valid_i = 1'b1;
    if1.s_inst_i  = 32'h201;
    if1.s_data_i  = 64'hB1;
    step();
    if1.s_inst_i  = 32'h202;
    if1.s_data_i  = 64'hB2;
    step();
    if1.flush_i   = 1'b1;
    if1.m_ready_i = 1'b1;
    if1.s_inst_i  = 32'h203;
    if1.s_data_i  = 64'hB3;
    #3;
    check_val("flush_pre_cnt", 64'(if1.cnt_o), 64'd2);
    step();
    if1.flush_i   = 1'b0;
    if1.s_valid_i = 1'b0;
    #3;
    check_val("flush_cnt", 64'(if1.cnt_o), 64'd0);
    check_val("flush_valid", 64'(if1.m_valid_o), 64'd0);
    check_val("flush_inst", 64'(if1.m_inst_o), 64'(NOP));
    check_val("flush_data", if1.m_data_o, 64'd0);

    // Flush in ONE with an accepted push and pop
    step();
    if1.s_valid_i = 1'b1;
    if1.s_inst_i  = 32'h301;
    if1.s_data_i  = 64'hC1;
    step();
    if1.flush_i   = 1'b1;
    if1.s_inst_i  = 32'h302;
    if1.s_data_i  = 64'hC2;
    #3;
    check_val("flush1_pre_ready", 64'(if1.s_ready_o), 64'd1);
    check_val("flush1_pre_cnt", 64'(if1.cnt_o), 64'd1);
    step();
    if1.flush_i   = 1'b0;
    if1.s_valid_i = 1'b0;
    #3;
    check_val("flush1_cnt", 64'(if1.cnt_o), 64'd0);
    check_val("flush1_inst", 64'(if1.m_inst_o), 64'(NOP));

    // Asynchronous reset while FULL
    step();
    if1.m_ready_i = 1'b0;
    if1.s_valid_i = 1'b1;
    if1.s_inst_i  = 32'h401;
    if1.s_data_i  = 64'hD1;
    step();
    if1.s_inst_i  = 32'h402;
    if1.s_data_i  = 64'hD2;
    step();
    if1.s_valid_i = 1'b0;
    #1;
    check_val("arst_pre_cnt", 64'(if1.cnt_o), 64'd2);
    #1;
    rstn = 1'b0;
    q1.delete();
    #1;
    check_val("arst_valid", 64'(if1.m_valid_o), 64'd0);
    check_val("arst_cnt", 64'(if1.cnt_o), 64'd0);
    check_val("arst_inst", 64'(if1.m_inst_o), 64'(NOP));
    check_val("arst_data", if1.m_data_o, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    if1.m_ready_i = 1'b1;

    // SKID=0 single-entry stream
    p0_start = pops0;
    for (int i = 0; i < 6; i++) begin
      step();
      if0.s_valid_i = 1'b1;
      if0.s_inst_i  = 32'h500 + 32'(i);
      if0.s_data_i  = 8'(i * 7 + 3);
      #3;
      check_val("s0_ready", 64'(if0.s_ready_o), 64'd1);
      check_val("s0_cnt", 64'(if0.cnt_o), (i == 0) ? 64'd0 : 64'd1);
    end
    step();
    if0.s_valid_i = 1'b0;
    #3;
    check_val("s0_last_inst", 64'(if0.m_inst_o), 64'h505);
    check_val("s0_throughput", 64'(pops0 - p0_start), 64'd5);
    step();
    if0.s_valid_i = 1'b1;
    if0.s_inst_i  = 32'h600;
    if0.s_data_i  = 8'h5A;
    step();
    if0.s_valid_i = 1'b0;
    if0.m_ready_i = 1'b0;
    #1;
    check_val("s0_comb_ready_lo", 64'(if0.s_ready_o), 64'd0);
    if0.m_ready_i = 1'b1;
    #1;
    check_val("s0_comb_ready_hi", 64'(if0.s_ready_o), 64'd1);
    step();
    #3;
    check_val("s0_drain_cnt", 64'(if0.cnt_o), 64'd0);
    check_val("s0_drain_inst", 64'(if0.m_inst_o), 64'(NOP));

    check_val("sb1_left", 64'(q1.size()), 64'd0);
    check_val("sb0_left", 64'(q0.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
